// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write bus of the
// program loader.
//
// Signals:
//   in_valid    stream source has a byte on in_data
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe (one-cycle pulse per word)
//   imem_addr   word address of the write
//   imem_wdata  instruction word to write
//
// Modports:
//   master  stream source / memory side (testbench or host bridge)
//   slave   the loader itself
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- writer side of the instruction memory read by fetch.
//
// Receives a byte stream (length LSB, length MSB, then N little-endian 32-bit
// words) and writes the words to word addresses 0..N-1. The pipeline is held
// off (cpu_hold) while a load is in progress.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     one-cycle load request; honoured only in IDLE or DONE
//   bus       imem_loader_if.slave: byte stream in, memory write bus out
//   busy      a load is in progress
//   done      last load completed; held until the next start or rst
//   err       last load overflowed DEPTH (or failed checksum); valid with done
//   cpu_hold  pipeline hold request, equal to busy
//
// Parameters:
//   ADDR_W    word-address width of the instruction memory (1..16);
//             DEPTH = 2**ADDR_W words
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  adds a trailing checksum byte (XOR of all length
//                            and data bytes); a mismatch sets err.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    // State entered once the last data word (or a zero length) is consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       asm_q;       // lanes 0..2; lane 3 comes straight from in_data
    logic              overflow_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
    logic              chk_err_q;
`endif

    logic in_ready;
    logic accept;
    logic start_ok;
    logic last_byte;
    logic last_word;
    logic in_range;

    assign accept    = bus.in_valid && in_ready;
    assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_byte = (byte_idx_q == 2'd3);
    assign last_word = (word_cnt_q == len_q - 16'd1);
    // Word counter is wider than the address: anything at or above DEPTH
    // still has bits set above ADDR_W.
    assign in_range  = ((word_cnt_q >> ADDR_W) == 16'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if ({bus.in_data, len_q[7:0]} == 16'd0) state_d = S_END;
                    else                                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_byte && last_word) state_d = S_END;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_LEN_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;   // write strobe is a single-cycle pulse
            if (start_ok) begin
                overflow_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q      <= '0;
                chk_err_q  <= 1'b0;
`endif
            end
            if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q <= xor_q ^ bus.in_data;
`endif
                unique case (state_q)
                    S_LEN_LO: len_q[7:0] <= bus.in_data;
                    S_LEN_HI: begin
                        len_q[15:8] <= bus.in_data;
                        word_cnt_q  <= '0;
                        byte_idx_q  <= '0;
                    end
                    S_DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= bus.in_data;
                            2'd1: asm_q[15:8]  <= bus.in_data;
                            2'd2: asm_q[23:16] <= bus.in_data;
                            default: begin
                                word_cnt_q <= word_cnt_q + 16'd1;
                                if (in_range) begin
                                    we_q    <= 1'b1;
                                    addr_q  <= word_cnt_q[ADDR_W-1:0];
                                    wdata_q <= {bus.in_data, asm_q};
                                end else begin
                                    overflow_q <= 1'b1;   // consumed, not written
                                end
                            end
                        endcase
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CHK: chk_err_q <= (bus.in_data != xor_q);
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = busy;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = done && (overflow_q || chk_err_q);
`else
    assign err = done && overflow_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- scoreboard bench for imem_loader.
//
// Stimulus tasks push the hand-computed write (address, word, expected cycle)
// into a queue as the 4th byte of each in-range word is offered; a negedge
// monitor pops and compares every imem_we pulse it sees.
// ADDR_W is 2 (DEPTH 4) so the overflow case is reachable with a short stream.
// Compile with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_imem_loader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } plan_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy, done, err, cpu_hold;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int      n_checks = 0;
    int      n_errors = 0;
    plan_t   plan_q[$];   // hand-computed writes for the load in progress
    wr_t     exp_q[$];    // scoreboard: writes due, with their cycle
    wr_t     mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h at cycle %0d, want no write",
                         bus.imem_addr, bus.imem_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr",  32'(bus.imem_addr), 32'(mon_e.addr));
                check("wr_data",  bus.imem_wdata, mon_e.data);
                check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    function automatic byte_q_t with_chk(input byte_q_t s);
        byte_q_t r;
        r = s;
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (s[i]) x ^= s[i];
            r.push_back(x);
        end
`endif
        return r;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_err",  32'(err), 32'd0);
    endtask

    // Offer each byte at a negedge; it is taken at the next posedge once
    // in_ready is seen. 'gap' idle cycles separate consecutive bytes.
    task automatic load(input byte_q_t s, input int gap);
        int    n_words;
        int    k;
        plan_t pe;
        n_words = (s.size() >= 2) ? int'({s[1], s[0]}) : 0;
        for (int p = 0; p < s.size(); p++) begin
            int waited;
            waited = 0;
            if (p > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = s[p];
            while (bus.in_ready !== 1'b1 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (bus.in_ready !== 1'b1) begin
                n_checks++;
                n_errors++;
                $display("FAIL byte_timeout: byte %0d got in_ready=%b, want 1 within 50 cycles", p, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            k = p - 2;
            if (p >= 2 && k % 4 == 3 && k / 4 < n_words && k / 4 < DEPTH) begin
                if (plan_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL plan_empty: got no planned write for word %0d, want one", k / 4);
                end else begin
                    pe = plan_q.pop_front();
                    exp_q.push_back('{addr: pe.addr, data: pe.data, cyc: cyc + 1});
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge right after the last byte was taken.
    task automatic finish_load(input string name, input logic exp_err);
        check({name, "_done"},  32'(done), 32'd1);
        check({name, "_err"},   32'(err), 32'(exp_err));
        check({name, "_busy"},  32'(busy), 32'd0);
        check({name, "_hold"},  32'(cpu_hold), 32'd0);
        check({name, "_ready"}, 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_held"}, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        byte_q_t s;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we",    32'(bus.imem_we), 32'd0);
        check("rst_addr",  32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        rst = 1'b0;

        // Two-word program, back-to-back bytes
        plan_q.push_back('{addr: 2'd0, data: 32'h0010_0013});
        plan_q.push_back('{addr: 2'd1, data: 32'h0020_0093});
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        pulse_start();
        load(with_chk(s), 0);
        finish_load("two_words", 1'b0);

        // Same program with 3 idle cycles between bytes
        plan_q.push_back('{addr: 2'd0, data: 32'h0010_0013});
        plan_q.push_back('{addr: 2'd1, data: 32'h0020_0093});
        pulse_start();
        load(with_chk(s), 3);
        finish_load("gapped", 1'b0);

        // Empty program
        s = '{8'h00, 8'h00};
        pulse_start();
        load(with_chk(s), 0);
        finish_load("empty", 1'b0);

        // Five words into a 4-word memory: last word consumed, not written
        plan_q.push_back('{addr: 2'd0, data: 32'h0302_0100});
        plan_q.push_back('{addr: 2'd1, data: 32'h1312_1110});
        plan_q.push_back('{addr: 2'd2, data: 32'h2322_2120});
        plan_q.push_back('{addr: 2'd3, data: 32'h3332_3130});
        s = '{8'h05, 8'h00};
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) s.push_back(8'((w << 4) | b));
        end
        pulse_start();
        load(with_chk(s), 0);
        finish_load("overflow", 1'b1);

        // Reset after two data bytes, then a fresh one-word load
        s = '{8'h01, 8'h00, 8'h11, 8'h22};
        pulse_start();
        load(s, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err",  32'(err), 32'd0);
        rst = 1'b0;
        plan_q.push_back('{addr: 2'd0, data: 32'hDDCC_BBAA});
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start();
        load(with_chk(s), 0);
        finish_load("after_abort", 1'b0);

        // One word 01 02 03 04 (checksum 05 when enabled)
        plan_q.push_back('{addr: 2'd0, data: 32'h0403_0201});
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        pulse_start();
        load(with_chk(s), 1);
        finish_load("chk_good", 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: word still written, err raised
        plan_q.push_back('{addr: 2'd0, data: 32'h0403_0201});
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        pulse_start();
        load(s, 0);
        finish_load("chk_bad", 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
